// File: rtl/preamble_wave_gen_pkg.sv
// Shared definitions for the Gen2 tag preamble waveform generator.
package preamble_wave_gen_pkg;

    // Mode encoding for the m input.
    localparam logic [1:0] MODE_FM0 = 2'd0;
    localparam logic [1:0] MODE_M2  = 2'd1;
    localparam logic [1:0] MODE_M4  = 2'd2;
    localparam logic [1:0] MODE_M8  = 2'd3;

    // Sync symbols, MSB is the first symbol sent.
    localparam logic [5:0] FM0_SYNC      = 6'b101001;
    localparam logic [5:0] FM0_VIOL_MASK = 6'b000010;
    localparam logic [5:0] MIL_SYNC      = 6'b010111;

    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

    // Halves per bit: 2 for FM0, 2*M for Miller.
    function automatic logic [4:0] bit_halves(input logic [1:0] mode);
        logic [4:0] h;
        case (mode)
            MODE_M2: h = 5'd4;
            MODE_M4: h = 5'd8;
            MODE_M8: h = 5'd16;
            default: h = 5'd2;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/preamble_line_encoder.sv
// Line encoder: turns one half-symbol description per cycle into the registered
// FM0 or Miller baseband level. Holds the baseband (b) and subcarrier (sc) state.
module preamble_line_encoder
    import preamble_wave_gen_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       emit,       // a half is produced on this edge; otherwise clear
    input  logic       bit_val,
    input  logic       viol,
    input  logic [3:0] half,
    input  logic [4:0] halves,
    input  logic       first_bit,
    input  logic [1:0] mode,
    output logic       tx
);

    logic b_q, b_d;
    logic sc_q, sc_d;
    logic prev_q, prev_d;
    logic tx_q, tx_d;

    // Next baseband, subcarrier and output level for the half being emitted.
    always_comb begin
        b_d    = b_q;
        sc_d   = sc_q;
        prev_d = prev_q;
        tx_d   = 1'b0;
        if (emit) begin
            if (mode == MODE_FM0) begin
                if (half == 4'd0 && !viol) b_d = ~b_d;
                if (half == 4'd1 && (!bit_val || viol)) b_d = ~b_d;
                sc_d = 1'b0;
                tx_d = b_d;
            end else begin
                // prev_q still holds the previous bit at half 0 of a new bit.
                if (half == 4'd0 && !first_bit && !bit_val && !prev_q) b_d = ~b_d;
                if ({1'b0, half} == (halves >> 1) && bit_val) b_d = ~b_d;
                sc_d = (first_bit && half == 4'd0) ? 1'b0 : ~sc_q;
                tx_d = 1'b1 ^ b_d ^ sc_d;
            end
            prev_d = bit_val;
        end else begin
            b_d    = 1'b0;
            sc_d   = 1'b0;
            prev_d = 1'b0;
        end
    end

    // Encoder state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_q    <= 1'b0;
            sc_q   <= 1'b0;
            prev_q <= 1'b0;
            tx_q   <= 1'b0;
        end else begin
            b_q    <= b_d;
            sc_q   <= sc_d;
            prev_q <= prev_d;
            tx_q   <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/preamble_wave_gen.sv
// Gen2 tag preamble generator: sequences pilot and sync symbols half by half
// and drives the line encoder. One clk cycle is one half subcarrier period.
module preamble_wave_gen
    import preamble_wave_gen_pkg::*;
#(
    parameter int unsigned FM0_PILOT       = 12,
    parameter int unsigned MIL_PILOT_SHORT = 4,
    parameter int unsigned MIL_PILOT_LONG  = 16,
    parameter int unsigned BIT_W           = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] m,
    input  logic       trext,
    input  logic       abort,
    output logic       tx,
    output logic       violation,
    output logic       active,
    output logic       done
);

    state_t           state_q;
    logic [1:0]       m_q;
    logic             trext_q;
    logic [3:0]       half_q;
    logic [BIT_W-1:0] bit_q;
    logic             active_q;
    logic             done_q;
    logic             viol_q;

    logic [1:0]       mode_s;
    logic             trext_s;
    logic [4:0]       halves;
    logic [BIT_W-1:0] pilot;
    logic             is_last;
    logic             last_half;
    logic [3:0]       nxt_half;
    logic [BIT_W-1:0] nxt_bit;
    logic             emit;
    logic             nxt_val;
    logic             nxt_viol;
    logic [2:0]       sync_idx;
    logic [5:0]       sync_sh;

    // Work out which half goes out on the coming edge and what symbol it belongs to.
    always_comb begin
        // In IDLE the start edge already emits, so use the live mode inputs.
        mode_s  = (state_q == IDLE) ? m : m_q;
        trext_s = (state_q == IDLE) ? trext : trext_q;
        halves  = bit_halves(mode_s);
        if (mode_s == MODE_FM0) pilot = trext_s ? BIT_W'(FM0_PILOT) : '0;
        else pilot = trext_s ? BIT_W'(MIL_PILOT_LONG) : BIT_W'(MIL_PILOT_SHORT);

        last_half = ({1'b0, half_q} == halves - 5'd1);
        is_last   = last_half && (bit_q == pilot + BIT_W'(5));

        if (state_q == IDLE) begin
            nxt_half = 4'd0;
            nxt_bit  = '0;
        end else if (last_half) begin
            nxt_half = 4'd0;
            nxt_bit  = bit_q + BIT_W'(1);
        end else begin
            nxt_half = half_q + 4'd1;
            nxt_bit  = bit_q;
        end

        emit = !abort && ((state_q == IDLE && start) || (state_q == SEND && !is_last));

        sync_idx = 3'(nxt_bit - pilot);
        sync_sh  = ((mode_s == MODE_FM0) ? FM0_SYNC : MIL_SYNC) << sync_idx;
        if (nxt_bit < pilot) begin
            nxt_val  = 1'b0;
            nxt_viol = 1'b0;
        end else begin
            nxt_val  = sync_sh[5];
            nxt_viol = (mode_s == MODE_FM0) && ((FM0_VIOL_MASK << sync_idx) != 6'd0) &&
                       sync_idx == 3'd4;
        end
    end

    // Sequencing FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            m_q      <= MODE_FM0;
            trext_q  <= 1'b0;
            half_q   <= 4'd0;
            bit_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            viol_q   <= 1'b0;
        end else if (abort) begin
            state_q  <= IDLE;
            half_q   <= 4'd0;
            bit_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            viol_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= SEND;
                        m_q      <= m;
                        trext_q  <= trext;
                        half_q   <= nxt_half;
                        bit_q    <= nxt_bit;
                        active_q <= 1'b1;
                        viol_q   <= nxt_viol;
                    end
                end
                SEND: begin
                    if (is_last) begin
                        state_q  <= FIN;
                        half_q   <= 4'd0;
                        bit_q    <= '0;
                        active_q <= 1'b0;
                        viol_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        half_q <= nxt_half;
                        bit_q  <= nxt_bit;
                        viol_q <= nxt_viol;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                    done_q   <= 1'b0;
                    viol_q   <= 1'b0;
                end
            endcase
        end
    end

    preamble_line_encoder u_enc (
        .clk       (clk),
        .reset     (reset),
        .emit      (emit),
        .bit_val   (nxt_val),
        .viol      (nxt_viol),
        .half      (nxt_half),
        .halves    (halves),
        .first_bit (nxt_bit == '0),
        .mode      (mode_s),
        .tx        (tx)
    );

    assign violation = viol_q;
    assign active    = active_q;
    assign done      = done_q;

endmodule
